// File: rtl/mem_wb_stage_lsu_pkg.sv
// Shared types for the MEM/WB stage: load encodings, stage FSM states and per-load metadata.
package mem_wb_stage_lsu_pkg;

  // Metadata fields are sized for the widest legal configuration; narrower builds zero-extend.
  localparam int MAX_RD_W  = 8;
  localparam int MAX_OFF_W = 3;

  typedef enum logic [2:0] {
    LT_NONE = 3'b000,
    LT_LB   = 3'b001,
    LT_LH   = 3'b010,
    LT_LW   = 3'b011,
    LT_LBU  = 3'b100,
    LT_LHU  = 3'b101,
    LT_LWU  = 3'b110,
    LT_LD   = 3'b111
  } load_type_e;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} wb_state_e;

  typedef struct packed {
    logic [MAX_RD_W-1:0]  rd;
    logic                 wb_en;
    logic                 fwb_en;
    load_type_e           load_type;
    logic [MAX_OFF_W-1:0] byte_off;
  } wb_meta_t;

  function automatic logic is_load(input load_type_e t);
    return t != LT_NONE;
  endfunction

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// Load-return aligner: shifts the bus word by the byte offset, then sign/zero-extends per load type.
module load_align_ext
  import mem_wb_stage_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] byte_off,
  input  load_type_e       load_type,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] sh;
  assign sh = rdata >> {byte_off, 3'b000};

  // Word-unsigned and doubleword loads have no meaning on a 32-bit datapath and return 0.
  always_comb begin
    data = '0;
    case (load_type)
      LT_LB:   data = XLEN'($signed(sh[7:0]));
      LT_LH:   data = XLEN'($signed(sh[15:0]));
      LT_LW:   data = XLEN'($signed(sh[31:0]));
      LT_LBU:  data = XLEN'(sh[7:0]);
      LT_LHU:  data = XLEN'(sh[15:0]);
      LT_LWU:  if (XLEN == 64) data = XLEN'(sh[31:0]);
      LT_LD:   if (XLEN == 64) data = sh;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage_lsu.sv
// MEM/WB pipeline register with a load-return unit: waits on dm_rvalid, captures under stall,
// and drains responses orphaned by a flush.
module mem_wb_stage_lsu
  import mem_wb_stage_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int RD_W  = 6,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wb_en_MEM,
  input  logic             fwb_en_MEM,
  input  logic [2:0]       load_type_MEM,
  input  logic [RD_W-1:0]  rd_addr_MEM,
  input  logic [XLEN-1:0]  alu_out_MEM,
  input  logic [OFF_W-1:0] byte_off_MEM,
  input  logic             dm_rvalid,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic             wb_valid,
  output logic             wb_en_WB,
  output logic             fwb_en_WB,
  output logic [RD_W-1:0]  rd_addr_WB,
  output logic [XLEN-1:0]  wb_data_WB,
  output logic             load_busy
);

  wb_state_e       state;
  wb_meta_t        meta;
  logic [XLEN-1:0] cap_q;
  logic [XLEN-1:0] align_src;
  logic [XLEN-1:0] ext_data;
  load_type_e      lt_in;
  logic            accept;
  logic            unused_meta;

  assign lt_in     = load_type_e'(load_type_MEM);
  assign in_ready  = !rst && (state == IDLE) && !stall;
  assign load_busy = (state != IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign align_src = (state == HOLD) ? cap_q : dm_rdata;
  assign unused_meta = ^{meta.rd, meta.byte_off};

  load_align_ext #(.XLEN(XLEN)) u_align (
    .rdata    (align_src),
    .byte_off (meta.byte_off[OFF_W-1:0]),
    .load_type(meta.load_type),
    .data     (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      meta       <= '0;
      cap_q      <= '0;
      wb_valid   <= 1'b0;
      wb_en_WB   <= 1'b0;
      fwb_en_WB  <= 1'b0;
      rd_addr_WB <= '0;
      wb_data_WB <= '0;
    end else if (flush) begin
      // Flush wins over stall; a response arriving with the flush is consumed and dropped.
      wb_valid  <= 1'b0;
      wb_en_WB  <= 1'b0;
      fwb_en_WB <= 1'b0;
      case (state)
        WAIT:    state <= dm_rvalid ? IDLE : DRAIN;
        HOLD:    state <= IDLE;
        DRAIN:   if (dm_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else if (stall) begin
      case (state)
        WAIT: if (dm_rvalid) begin
          cap_q <= dm_rdata;
          state <= HOLD;
        end
        DRAIN:   if (dm_rvalid) state <= IDLE;
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_load(lt_in)) begin
            meta <= '{rd: MAX_RD_W'(rd_addr_MEM), wb_en: wb_en_MEM, fwb_en: fwb_en_MEM,
                      load_type: lt_in, byte_off: MAX_OFF_W'(byte_off_MEM)};
            state     <= WAIT;
            wb_valid  <= 1'b0;
            wb_en_WB  <= 1'b0;
            fwb_en_WB <= 1'b0;
          end else if (accept) begin
            wb_valid   <= 1'b1;
            wb_en_WB   <= wb_en_MEM;
            fwb_en_WB  <= fwb_en_MEM;
            rd_addr_WB <= rd_addr_MEM;
            wb_data_WB <= alu_out_MEM;
          end else begin
            wb_valid  <= 1'b0;
            wb_en_WB  <= 1'b0;
            fwb_en_WB <= 1'b0;
          end
        end
        WAIT, HOLD: begin
          // align_src already selects the capture register while in HOLD.
          if (state == HOLD || dm_rvalid) begin
            wb_valid   <= 1'b1;
            wb_en_WB   <= meta.wb_en;
            fwb_en_WB  <= meta.fwb_en;
            rd_addr_WB <= meta.rd[RD_W-1:0];
            wb_data_WB <= ext_data;
            state      <= IDLE;
          end else begin
            wb_valid  <= 1'b0;
            wb_en_WB  <= 1'b0;
            fwb_en_WB <= 1'b0;
          end
        end
        default: begin
          wb_valid  <= 1'b0;
          wb_en_WB  <= 1'b0;
          fwb_en_WB <= 1'b0;
          if (dm_rvalid) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_lsu.sv
// Bench: 32- and 64-bit instances driven in lockstep, checked every cycle against a
// transaction-level model (outstanding response / discard / captured data).
module tb_mem_wb_stage_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, in_valid, wb_en, fwb_en, rv;
  logic [2:0]  lt, off;
  logic [5:0]  rd;
  logic [63:0] alu, rdata;

  logic        r32_ready, r32_valid, r32_we, r32_fwe, r32_busy;
  logic [5:0]  r32_rd;
  logic [31:0] r32_data;
  logic        r64_ready, r64_valid, r64_we, r64_fwe, r64_busy;
  logic [5:0]  r64_rd;
  logic [63:0] r64_data;

  mem_wb_stage_lsu #(.XLEN(32), .RD_W(6)) dut32 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_ready(r32_ready),
    .wb_en_MEM(wb_en), .fwb_en_MEM(fwb_en), .load_type_MEM(lt), .rd_addr_MEM(rd),
    .alu_out_MEM(alu[31:0]), .byte_off_MEM(off[1:0]), .dm_rvalid(rv), .dm_rdata(rdata[31:0]),
    .wb_valid(r32_valid), .wb_en_WB(r32_we), .fwb_en_WB(r32_fwe), .rd_addr_WB(r32_rd),
    .wb_data_WB(r32_data), .load_busy(r32_busy));

  mem_wb_stage_lsu #(.XLEN(64), .RD_W(6)) dut64 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_ready(r64_ready),
    .wb_en_MEM(wb_en), .fwb_en_MEM(fwb_en), .load_type_MEM(lt), .rd_addr_MEM(rd),
    .alu_out_MEM(alu), .byte_off_MEM(off), .dm_rvalid(rv), .dm_rdata(rdata),
    .wb_valid(r64_valid), .wb_en_WB(r64_we), .fwb_en_WB(r64_fwe), .rd_addr_WB(r64_rd),
    .wb_data_WB(r64_data), .load_busy(r64_busy));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load result: plain shift-and-extend arithmetic, masked to the datapath width.
  function automatic logic [63:0] ext(input int xl, input logic [2:0] t, input logic [2:0] o,
                                      input logic [63:0] d);
    logic [63:0] s, r, m;
    m = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    s = (d & m) >> (8 * o);
    case (t)
      3'd1:    r = {{56{s[7]}}, s[7:0]};
      3'd2:    r = {{48{s[15]}}, s[15:0]};
      3'd3:    r = {{32{s[31]}}, s[31:0]};
      3'd4:    r = {56'h0, s[7:0]};
      3'd5:    r = {48'h0, s[15:0]};
      3'd6:    r = (xl == 64) ? {32'h0, s[31:0]} : 64'h0;
      3'd7:    r = (xl == 64) ? s : 64'h0;
      default: r = 64'h0;
    endcase
    return r & m;
  endfunction

  // Model: owed = a load response is still due; discard = that response is to be dropped;
  // have_cap = a response arrived under stall and waits to retire.
  bit          owed, discard, have_cap;
  logic [63:0] cap;
  logic [5:0]  m_rd;
  logic        m_we, m_fwe;
  logic [2:0]  m_lt, m_off;
  logic        e_valid, e_we, e_fwe;
  logic [5:0]  e_rd;
  logic [63:0] e_d32, e_d64;

  task automatic model_reset();
    owed = 0; discard = 0; have_cap = 0; cap = '0;
    m_rd = '0; m_we = 0; m_fwe = 0; m_lt = '0; m_off = '0;
    e_valid = 0; e_we = 0; e_fwe = 0; e_rd = '0; e_d32 = '0; e_d64 = '0;
  endtask

  task automatic clr();
    e_valid = 0; e_we = 0; e_fwe = 0;
  endtask

  task automatic retire(input logic [63:0] d);
    e_valid = 1; e_we = m_we; e_fwe = m_fwe; e_rd = m_rd;
    e_d32 = ext(32, m_lt, {1'b0, m_off[1:0]}, d);
    e_d64 = ext(64, m_lt, m_off, d);
  endtask

  task automatic model_step();
    bit r;
    r = rv && owed;
    if (flush) begin
      clr();
      have_cap = 0;
      if (r) begin owed = 0; discard = 0; end
      else if (owed) discard = 1;
    end else if (stall) begin
      if (r) begin
        owed = 0;
        if (!discard) begin have_cap = 1; cap = rdata; end
        discard = 0;
      end
    end else if (have_cap) begin
      retire(cap);
      have_cap = 0;
    end else if (owed) begin
      clr();
      if (r) begin
        owed = 0;
        if (discard) discard = 0;
        else retire(rdata);
      end
    end else if (in_valid) begin
      if (lt != 3'd0) begin
        owed = 1; m_rd = rd; m_we = wb_en; m_fwe = fwb_en; m_lt = lt; m_off = off;
        clr();
      end else begin
        e_valid = 1; e_we = wb_en; e_fwe = fwb_en; e_rd = rd;
        e_d32 = {32'h0, alu[31:0]}; e_d64 = alu;
      end
    end else clr();
  endtask

  task automatic compare_all();
    chk("valid32", r32_valid, e_valid);
    chk("valid64", r64_valid, e_valid);
    chk("wben32", r32_we, e_we);
    chk("wben64", r64_we, e_we);
    chk("fwben32", r32_fwe, e_fwe);
    chk("fwben64", r64_fwe, e_fwe);
    chk("busy32", r32_busy, owed || have_cap);
    chk("busy64", r64_busy, owed || have_cap);
    if (e_valid) begin
      chk("rd32", r32_rd, e_rd);
      chk("rd64", r64_rd, e_rd);
      chk("data32", r32_data, e_d32);
      chk("data64", r64_data, e_d64);
    end
  endtask

  // One cycle: check in_ready on the settled inputs, advance the model at the edge, compare after.
  task automatic tick();
    #1;
    chk("ready32", r32_ready, !rst && !(owed || have_cap) && !stall);
    chk("ready64", r64_ready, !rst && !(owed || have_cap) && !stall);
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; rv = 0; lt = '0; off = '0;
  endtask

  task automatic set_op(input logic [2:0] t, input logic [2:0] o, input logic [5:0] r,
                        input logic [63:0] a);
    in_valid = 1; lt = t; off = o; rd = r; alu = a; wb_en = 1; fwb_en = 0;
  endtask

  initial begin
    rst = 1; idle(); rd = '0; alu = '0; rdata = '0; wb_en = 0; fwb_en = 0;
    model_reset();

    chk("m_lb", ext(32, 3'd1, 3'd2, 64'h00F0_0000), 64'hFFFF_FFF0);
    chk("m_lbu", ext(32, 3'd4, 3'd2, 64'h00F0_0000), 64'h0000_00F0);
    chk("m_lh", ext(32, 3'd2, 3'd2, 64'h8001_0000), 64'hFFFF_8001);
    chk("m_ld", ext(64, 3'd7, 3'd0, 64'h8000_0000_0000_0001), 64'h8000_0000_0000_0001);
    chk("m_lw64", ext(64, 3'd3, 3'd4, 64'hFFFF_FFFF_0000_0000), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("m_lwu64", ext(64, 3'd6, 3'd4, 64'hFFFF_FFFF_0000_0000), 64'h0000_0000_FFFF_FFFF);

    @(negedge clk);
    tick(); tick();
    chk("rst_data32", r32_data, 0);
    chk("rst_rd64", r64_rd, 0);
    rst = 0;
    tick();

    set_op(3'd0, 3'd0, 6'd5, 64'h1234_5678); tick(); idle();
    chk("nl_valid", r32_valid, 1);
    chk("nl_data", r32_data, 32'h1234_5678);
    chk("nl_rd", r32_rd, 5);

    for (int k = 0; k < 2; k++) begin
      set_op(k == 0 ? 3'd1 : 3'd4, 3'd2, 6'd7, 64'h0); tick(); idle();
      tick(); tick();
      chk("lb_busy", r32_busy, 1);
      rv = 1; rdata = 64'h00F0_0000; tick(); idle();
      chk("lb_data", r32_data, k == 0 ? 32'hFFFF_FFF0 : 32'h0000_00F0);
      chk("lb_busy_end", r32_busy, 0);
    end

    set_op(3'd2, 3'd2, 6'd9, 64'h0); tick(); idle();
    rv = 1; rdata = 64'h8001_0000; stall = 1; tick();
    rv = 0; tick();
    chk("lh_hold_valid", r32_valid, 0);
    chk("lh_hold_busy", r32_busy, 1);
    stall = 0; tick(); idle();
    chk("lh_data", r32_data, 32'hFFFF_8001);

    set_op(3'd3, 3'd0, 6'd10, 64'h0); tick(); idle();
    flush = 1; tick(); flush = 0;
    rv = 1; rdata = 64'hDEAD_BEEF; tick(); idle();
    chk("fl_valid", r32_valid, 0);
    #1 chk("fl_ready", r32_ready, 1);
    set_op(3'd0, 3'd0, 6'd3, 64'hCAFE); tick(); idle();
    chk("fl_next", r32_data, 32'hCAFE);

    set_op(3'd7, 3'd0, 6'd11, 64'h0); tick(); idle();
    rv = 1; rdata = 64'h8000_0000_0000_0001; tick(); idle();
    chk("ld64", r64_data, 64'h8000_0000_0000_0001);
    chk("ld32_zero", r32_data, 0);
    chk("ld32_we", r32_we, 1);
    for (int k = 0; k < 2; k++) begin
      set_op(k == 0 ? 3'd3 : 3'd6, 3'd4, 6'd12, 64'h0); tick(); idle();
      rv = 1; rdata = 64'hFFFF_FFFF_0000_0000; tick(); idle();
      chk("lw64", r64_data, k == 0 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF);
    end

    set_op(3'd3, 3'd0, 6'd13, 64'h0); tick(); idle();
    #1 rst = 1;
    #1;
    chk("ar_busy", r64_busy, 0);
    chk("ar_valid", r64_valid, 0);
    chk("ar_ready", r64_ready, 0);
    chk("ar_data", r64_data, 0);
    model_reset();
    tick();
    rst = 0; tick();
    rv = 1; rdata = 64'h1111_2222_3333_4444; tick(); idle();
    chk("stray_valid", r32_valid, 0);
    chk("stray_busy", r64_busy, 0);

    for (int n = 0; n < 3000; n++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      in_valid = $urandom_range(0, 1);
      lt       = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
      off      = 3'($urandom_range(0, 7));
      rd       = 6'($urandom);
      alu      = {$urandom, $urandom};
      wb_en    = $urandom_range(0, 1);
      fwb_en   = $urandom_range(0, 1);
      rv       = owed && ($urandom_range(0, 2) == 0);
      rdata    = {$urandom, $urandom};
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
